// File: rtl/sha256_golden_nonce_filter_pkg.sv
// Shared SHA-256 datapath definitions: widths, byte-swap and word-select helpers,
// and the stage-1 compare record carried by the golden-nonce filter.
package sha256_golden_nonce_filter_pkg;

  localparam int HASH_W  = 256;
  localparam int NONCE_W = 32;
  localparam int WORD_W  = 32;
  localparam int HALF_W  = HASH_W / 2;
  localparam int N_WORDS = HASH_W / WORD_W;

  function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [WORD_W-1:0] word_sel(input logic [HASH_W-1:0] h, input int k);
    return h[WORD_W*k +: WORD_W];
  endfunction

  // Word k of the numeric value is the byte-reversed H_k, so H7 lands in the MSBs.
  function automatic logic [HASH_W-1:0] hash_to_value(input logic [HASH_W-1:0] h);
    logic [HASH_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_WORDS; k++) begin
      v[WORD_W*k +: WORD_W] = bswap32(word_sel(h, k));
    end
    return v;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [NONCE_W-1:0] nonce;
    logic               hi_lt;
    logic               hi_eq;
    logic               lo_le;
  } cmp_stage_t;

endpackage

// File: rtl/sha256_golden_nonce_filter_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head (rd_data).
// Occupancy counts storage plus the head register; overflow is reported per cycle.
module golden_nonce_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_drop,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  mem_cnt;
  logic [OCC_W-1:0]  occ;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              pop;
  logic              wr_accept;
  logic              load;

  assign occ       = mem_cnt + OCC_W'(out_valid);
  assign full      = (occ == OCC_W'(DEPTH));
  assign pop       = out_valid & rd_ready;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign wr_accept = wr_en & (~full | pop);
  assign wr_drop   = wr_en & full & ~pop;
  assign load      = (mem_cnt != '0) & (~out_valid | pop);

  assign rd_valid = out_valid;
  assign rd_data  = out_data;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load) begin
        out_data  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + PTR_W'(1);
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      case ({wr_accept, load})
        2'b10:   mem_cnt <= mem_cnt + OCC_W'(1);
        2'b01:   mem_cnt <= mem_cnt - OCC_W'(1);
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

endmodule

// File: rtl/sha256_golden_nonce_filter.sv
// Golden-nonce filter: byte-reorders each SHA-256 result, compares it against the
// loaded target in two pipeline stages and queues qualifying nonces for reporting.
module sha256_golden_nonce_filter
  import sha256_golden_nonce_filter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32,
  parameter int DROP_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hash_valid,
  input  logic [HASH_W-1:0]  hash,
  input  logic [NONCE_W-1:0] nonce_in,
  input  logic               target_load,
  input  logic [HASH_W-1:0]  target_in,
  output logic               gn_valid,
  input  logic               gn_ready,
  output logic [NONCE_W-1:0] gn_nonce,
  output logic [CNT_W-1:0]   hash_count,
  output logic [DROP_W-1:0]  drop_count,
  output logic               fifo_full
);

  logic [HASH_W-1:0]  target_q;
  logic [HASH_W-1:0]  hash_value;
  cmp_stage_t         s1_q;
  logic               golden;
  logic               s2_valid_q;
  logic [NONCE_W-1:0] s2_nonce_q;
  logic [CNT_W-1:0]   hash_count_q;
  logic [DROP_W-1:0]  drop_count_q;
  logic               fifo_drop;

  assign hash_value = hash_to_value(hash);
  assign golden     = s1_q.hi_lt | (s1_q.hi_eq & s1_q.lo_le);

  // Stage 1 always sees the target as it was before this edge, so a hash that
  // coincides with target_load is judged against the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q     <= '0;
      s1_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_nonce_q   <= '0;
      hash_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      if (target_load) begin
        target_q <= target_in;
      end
      s1_q.valid <= hash_valid;
      s1_q.nonce <= nonce_in;
      s1_q.hi_lt <= hash_value[HASH_W-1:HALF_W] <  target_q[HASH_W-1:HALF_W];
      s1_q.hi_eq <= hash_value[HASH_W-1:HALF_W] == target_q[HASH_W-1:HALF_W];
      s1_q.lo_le <= hash_value[HALF_W-1:0]      <= target_q[HALF_W-1:0];
      s2_valid_q <= s1_q.valid & golden;
      s2_nonce_q <= s1_q.nonce;
      if (hash_valid) begin
        hash_count_q <= hash_count_q + CNT_W'(1);
      end
      if (fifo_drop && (drop_count_q != '1)) begin
        drop_count_q <= drop_count_q + DROP_W'(1);
      end
    end
  end

  golden_nonce_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (NONCE_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (s2_valid_q),
    .wr_data  (s2_nonce_q),
    .wr_drop  (fifo_drop),
    .rd_valid (gn_valid),
    .rd_ready (gn_ready),
    .rd_data  (gn_nonce),
    .full     (fifo_full)
  );

  assign hash_count = hash_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_sha256_golden_nonce_filter.sv
// Directed bench for sha256_golden_nonce_filter; a second instance with a 4-bit
// hash counter shares the stimulus so counter wrap can be reached quickly.
module tb_sha256_golden_nonce_filter;

  logic         clk;
  logic         rst;
  logic         hash_valid;
  logic [255:0] hash;
  logic [31:0]  nonce_in;
  logic         target_load;
  logic [255:0] target_in;
  logic         gn_ready;
  logic         gn_valid;
  logic [31:0]  gn_nonce;
  logic [31:0]  hash_count;
  logic [7:0]   drop_count;
  logic         fifo_full;
  logic         s_gn_valid;
  logic [31:0]  s_gn_nonce;
  logic [3:0]   s_hash_count;
  logic [7:0]   s_drop_count;
  logic         s_fifo_full;

  int tests;
  int fails;
  int total;

  sha256_golden_nonce_filter dut (
    .clk(clk), .rst(rst), .hash_valid(hash_valid), .hash(hash), .nonce_in(nonce_in),
    .target_load(target_load), .target_in(target_in), .gn_valid(gn_valid),
    .gn_ready(gn_ready), .gn_nonce(gn_nonce), .hash_count(hash_count),
    .drop_count(drop_count), .fifo_full(fifo_full)
  );

  sha256_golden_nonce_filter #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .hash_valid(hash_valid), .hash(hash), .nonce_in(nonce_in),
    .target_load(target_load), .target_in(target_in), .gn_valid(s_gn_valid),
    .gn_ready(gn_ready), .gn_nonce(s_gn_nonce), .hash_count(s_hash_count),
    .drop_count(s_drop_count), .fifo_full(s_fifo_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [255:0] h, input logic [31:0] n);
    hash = h; nonce_in = n; hash_valid = 1'b1;
    step();
    hash_valid = 1'b0;
    total++;
  endtask

  task automatic test_reset();
    rst = 1'b1; hash_valid = 1'b0; hash = '0; nonce_in = '0;
    target_load = 1'b0; target_in = '0; gn_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    total = 0;
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL rst_gn_valid: got %b expected 0", gn_valid); end
    tests++; if (gn_nonce !== 32'h0) begin fails++; $display("FAIL rst_gn_nonce: got %h expected 0", gn_nonce); end
    tests++; if (hash_count !== 32'h0) begin fails++; $display("FAIL rst_hash_count: got %0d expected 0", hash_count); end
    tests++; if (drop_count !== 8'h0) begin fails++; $display("FAIL rst_drop_count: got %0d expected 0", drop_count); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL rst_fifo_full: got %b expected 0", fifo_full); end
  endtask

  task automatic test_latency();
    logic [255:0] h;
    target_in = {32'h00000000, 32'hFFFF0000, 192'h0};
    target_load = 1'b1;
    step();
    target_load = 1'b0;
    // V = 00000000_0000FFFF_..._78563412 sits below the target
    h = '0;
    h[223:192] = 32'hFFFF0000;
    h[31:0]    = 32'h12345678;
    send(h, 32'hDEADBEEF);
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL lat_n0: got %b expected 0", gn_valid); end
    step();
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL lat_n1: got %b expected 0", gn_valid); end
    step();
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL lat_n2: got %b expected 0", gn_valid); end
    step();
    tests++; if (gn_valid !== 1'b1) begin fails++; $display("FAIL lat_n3_valid: got %b expected 1", gn_valid); end
    tests++; if (gn_nonce !== 32'hDEADBEEF) begin fails++; $display("FAIL lat_n3_nonce: got %h expected deadbeef", gn_nonce); end
    tests++; if (hash_count !== 32'd1) begin fails++; $display("FAIL lat_hash_count: got %0d expected 1", hash_count); end
    gn_ready = 1'b1;
    step();
    gn_ready = 1'b0;
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL lat_pop_valid: got %b expected 0", gn_valid); end
    tests++; if (gn_nonce !== 32'hDEADBEEF) begin fails++; $display("FAIL lat_hold_nonce: got %h expected deadbeef", gn_nonce); end
  endtask

  task automatic test_boundary();
    logic [255:0] h;
    h = '0;
    h[223:192] = 32'h0000FFFF;          // V == target
    send(h, 32'h1);
    h[31:0] = 32'h01000000;             // V == target + 1
    send(h, 32'h2);
    h = '0;
    h[255:224] = 32'h01000000;          // upper word of V above target
    send(h, 32'h3);
    idle(4);
    tests++; if (gn_valid !== 1'b1) begin fails++; $display("FAIL eq_valid: got %b expected 1", gn_valid); end
    tests++; if (gn_nonce !== 32'h1) begin fails++; $display("FAIL eq_nonce: got %h expected 1", gn_nonce); end
    gn_ready = 1'b1;
    step();
    gn_ready = 1'b0;
    idle(3);
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL above_rejected: got valid=%b nonce=%h expected valid 0", gn_valid, gn_nonce); end
    tests++; if (hash_count !== 32'(total)) begin fails++; $display("FAIL bnd_hash_count: got %0d expected %0d", hash_count, total); end
  endtask

  task automatic test_fill_drop();
    logic [255:0] h;
    h = '0;
    h[223:192] = 32'h0000FFFF;
    h[31:0]    = 32'h01000000;
    // Loaded on the same edge as this hash, so the old target still rejects it.
    target_in = '1;
    target_load = 1'b1;
    hash = h; nonce_in = 32'd9; hash_valid = 1'b1;
    step();
    total++;
    target_load = 1'b0;
    for (int i = 10; i <= 15; i++) begin
      hash = {8{32'hA5A5A5A5}}; nonce_in = 32'(i);
      step();
      total++;
    end
    hash_valid = 1'b0;
    idle(5);
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b expected 1", fifo_full); end
    tests++; if (drop_count !== 8'd2) begin fails++; $display("FAIL fill_drop: got %0d expected 2", drop_count); end
    gn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (gn_valid !== 1'b1 || gn_nonce !== 32'(10 + i)) begin
        fails++; $display("FAIL fill_pop%0d: got valid=%b nonce=%0d expected valid 1 nonce %0d", i, gn_valid, gn_nonce, 10 + i);
      end
      step();
    end
    gn_ready = 1'b0;
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL fill_empty: got %b expected 0", gn_valid); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL fill_not_full: got %b expected 0", fifo_full); end
  endtask

  task automatic test_back_to_back();
    hash_valid = 1'b1;
    for (int i = 20; i <= 23; i++) begin
      hash = {8{32'h0F0F0F0F}}; nonce_in = 32'(i);
      step();
      total++;
    end
    hash_valid = 1'b0;
    idle(5);
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL b2b_full_before: got %b expected 1", fifo_full); end
    send({8{32'h0F0F0F0F}}, 32'd24);
    step();
    gn_ready = 1'b1;    // pop of 20 lands on the same edge as the push of 24
    step();
    gn_ready = 1'b0;
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL b2b_full_after: got %b expected 1", fifo_full); end
    tests++; if (drop_count !== 8'd2) begin fails++; $display("FAIL b2b_no_drop: got %0d expected 2", drop_count); end
    gn_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (gn_valid !== 1'b1 || gn_nonce !== 32'(21 + i)) begin
        fails++; $display("FAIL b2b_pop%0d: got valid=%b nonce=%0d expected valid 1 nonce %0d", i, gn_valid, gn_nonce, 21 + i);
      end
      step();
    end
    gn_ready = 1'b0;
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b expected 0", gn_valid); end
  endtask

  task automatic test_drop_saturation();
    hash_valid = 1'b1;
    hash = '0;
    for (int i = 0; i < 100; i++) begin
      nonce_in = 32'(100 + i);
      step();
      total++;
    end
    hash_valid = 1'b0;
    idle(3);
    tests++; if (drop_count !== 8'd98) begin fails++; $display("FAIL sat_mid: got %0d expected 98", drop_count); end
    hash_valid = 1'b1;
    for (int i = 100; i < 300; i++) begin
      nonce_in = 32'(100 + i);
      step();
      total++;
    end
    hash_valid = 1'b0;
    idle(3);
    tests++; if (drop_count !== 8'hFF) begin fails++; $display("FAIL sat_end: got %h expected ff", drop_count); end
    tests++; if (gn_nonce !== 32'd100) begin fails++; $display("FAIL sat_head: got %0d expected 100", gn_nonce); end
    gn_ready = 1'b1;
    idle(6);
    gn_ready = 1'b0;
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL sat_drained: got %b expected 0", gn_valid); end
  endtask

  task automatic test_count_wrap();
    int n;
    tests++; if (hash_count !== 32'(total)) begin fails++; $display("FAIL cnt_total: got %0d expected %0d", hash_count, total); end
    gn_ready = 1'b1;
    n = 15 - (total % 16);
    for (int i = 0; i < n; i++) send('0, 32'(i));
    tests++; if (s_hash_count !== 4'hF) begin fails++; $display("FAIL cnt_at_max: got %h expected f", s_hash_count); end
    send('0, 32'hFF);
    tests++; if (s_hash_count !== 4'h0) begin fails++; $display("FAIL cnt_wrap: got %h expected 0", s_hash_count); end
    tests++; if (hash_count !== 32'(total)) begin fails++; $display("FAIL cnt_total2: got %0d expected %0d", hash_count, total); end
    idle(4);
    gn_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [255:0] h;
    hash_valid = 1'b1;
    hash = '0;
    for (int i = 40; i <= 42; i++) begin
      nonce_in = 32'(i);
      step();
    end
    hash_valid = 1'b0;
    idle(5);
    tests++; if (gn_valid !== 1'b1 || gn_nonce !== 32'd40) begin fails++; $display("FAIL pre_rst: got valid=%b nonce=%0d expected valid 1 nonce 40", gn_valid, gn_nonce); end
    hash_valid = 1'b1;
    nonce_in = 32'd43; step();
    nonce_in = 32'd44; step();
    hash_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total = 0;
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid: got %b expected 0", gn_valid); end
    tests++; if (gn_nonce !== 32'h0) begin fails++; $display("FAIL mid_rst_nonce: got %h expected 0", gn_nonce); end
    tests++; if (hash_count !== 32'h0) begin fails++; $display("FAIL mid_rst_hash_count: got %0d expected 0", hash_count); end
    tests++; if (drop_count !== 8'h0) begin fails++; $display("FAIL mid_rst_drop: got %0d expected 0", drop_count); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL mid_rst_full: got %b expected 0", fifo_full); end
    idle(5);
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_late_push: got valid=%b nonce=%h expected valid 0", gn_valid, gn_nonce); end
    // Target is back to zero: V=1 must be rejected and V=0 accepted.
    h = '0;
    h[31:0] = 32'h01000000;
    send(h, 32'd50);
    send('0, 32'd51);
    idle(4);
    tests++; if (gn_valid !== 1'b1 || gn_nonce !== 32'd51) begin fails++; $display("FAIL tgt0: got valid=%b nonce=%0d expected valid 1 nonce 51", gn_valid, gn_nonce); end
    tests++; if (hash_count !== 32'd2) begin fails++; $display("FAIL tgt0_hash_count: got %0d expected 2", hash_count); end
    gn_ready = 1'b1;
    step();
    gn_ready = 1'b0;
    tests++; if (gn_valid !== 1'b0) begin fails++; $display("FAIL tgt0_only_one: got valid=%b nonce=%0d expected valid 0", gn_valid, gn_nonce); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    total = 0;
    test_reset();
    test_latency();
    test_boundary();
    test_fill_drop();
    test_back_to_back();
    test_drop_saturation();
    test_count_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
